// File: rtl/fifo_lifo_buf.sv
// Single-clock FIFO/LIFO buffer over an inferred synchronous RAM.
// It provides occupancy count, threshold flags and sticky overflow/underflow errors.
module fifo_lifo_buf #(
    parameter int B     = 8,
    parameter int W     = 4,
    parameter int MODE  = 0,
    parameter int AF_TH = 2**W - 1,
    parameter int AE_TH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         r_valid,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);
    localparam int         DEPTH    = 2**W;
    localparam logic [W:0] FULL_CNT = (W+1)'(DEPTH);
    localparam logic [W:0] CNT_ONE  = (W+1)'(1);
    localparam logic [W-1:0] PTR_ONE = W'(1);

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] wp, rp, waddr, raddr;
    logic         pass, wa, ra;

    // LIFO rd&wr hands the incoming word straight back and leaves the stack untouched
    assign pass = (MODE == 1) && rd && wr;
    assign wa   = !pass && wr && (!full || (rd && (MODE == 0)));
    assign ra   = !pass && rd && !empty;

    // In LIFO mode the stack pointer is the occupancy count itself
    assign waddr = (MODE == 1) ? count[W-1:0] : wp;
    assign raddr = (MODE == 1) ? W'(count - CNT_ONE) : rp;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign almost_empty = (int'(count) <= AE_TH);
    assign almost_full  = (int'(count) >= AF_TH);

    always_ff @(posedge clk) begin
        if (wa && !reset)
            mem[waddr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            r_valid <= ra || pass;
            // Non-blocking read gives old contents on a same-address write
            if (pass)
                r_data <= w_data;
            else if (ra)
                r_data <= mem[raddr];
            if (wa)
                wp <= wp + PTR_ONE;
            if (ra)
                rp <= rp + PTR_ONE;
            case ({wa, ra})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr && !wa && !pass)
                overflow <= 1'b1;
            if (rd && !ra && !pass)
                underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_lifo_buf.sv
// Bench for fifo_lifo_buf: FIFO vector table, LIFO corner sequence,
// then randomized traffic on both modes against queue-based reference models.
module tb_fifo_lifo_buf;
    typedef struct packed {
        logic       rv;
        logic [7:0] rd;
        logic [2:0] cnt;
        logic       empty, full, ae, af, ov, un;
    } obs_t;

    typedef struct {
        logic       rst, wr, rd;
        logic [7:0] d;
        logic       rv;
        logic [7:0] rdata;
        int         cnt;
        logic       ov, un;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       f_wr, f_rd, l_wr, l_rd;
    logic [7:0] f_wdata, l_wdata, f_rdata, l_rdata;
    logic       f_rvalid, f_empty, f_full, f_ae, f_af, f_ov, f_un;
    logic       l_rvalid, l_empty, l_full, l_ae, l_af, l_ov, l_un;
    logic [2:0] f_count, l_count;
    obs_t       f_obs, l_obs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fifo_lifo_buf #(.B(8), .W(2), .MODE(0), .AF_TH(3), .AE_TH(1)) u_fifo (
        .clk(clk), .reset(reset), .wr(f_wr), .w_data(f_wdata), .rd(f_rd),
        .r_data(f_rdata), .r_valid(f_rvalid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
        .overflow(f_ov), .underflow(f_un)
    );

    fifo_lifo_buf #(.B(8), .W(2), .MODE(1), .AF_TH(3), .AE_TH(1)) u_lifo (
        .clk(clk), .reset(reset), .wr(l_wr), .w_data(l_wdata), .rd(l_rd),
        .r_data(l_rdata), .r_valid(l_rvalid), .empty(l_empty), .full(l_full),
        .almost_empty(l_ae), .almost_full(l_af), .count(l_count),
        .overflow(l_ov), .underflow(l_un)
    );

    always_comb begin
        f_obs = '{rv: f_rvalid, rd: f_rdata, cnt: f_count, empty: f_empty, full: f_full,
                  ae: f_ae, af: f_af, ov: f_ov, un: f_un};
        l_obs = '{rv: l_rvalid, rd: l_rdata, cnt: l_count, empty: l_empty, full: l_full,
                  ae: l_ae, af: l_af, ov: l_ov, un: l_un};
    end

    // Expected observation; flags follow from the occupancy with depth 4, AF_TH=3, AE_TH=1
    function automatic obs_t mk(input logic rv, input logic [7:0] rdv, input int cnt,
                                input logic ov, input logic un);
        obs_t o;
        o.rv    = rv;
        o.rd    = rdv;
        o.cnt   = 3'(cnt);
        o.empty = (cnt == 0);
        o.full  = (cnt == 4);
        o.ae    = (cnt <= 1);
        o.af    = (cnt >= 3);
        o.ov    = ov;
        o.un    = un;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".r_valid"},      32'(a.rv),    32'(e.rv));
        chk({tag, ".r_data"},       32'(a.rd),    32'(e.rd));
        chk({tag, ".count"},        32'(a.cnt),   32'(e.cnt));
        chk({tag, ".empty"},        32'(a.empty), 32'(e.empty));
        chk({tag, ".full"},         32'(a.full),  32'(e.full));
        chk({tag, ".almost_empty"}, 32'(a.ae),    32'(e.ae));
        chk({tag, ".almost_full"},  32'(a.af),    32'(e.af));
        chk({tag, ".overflow"},     32'(a.ov),    32'(e.ov));
        chk({tag, ".underflow"},    32'(a.un),    32'(e.un));
    endtask

    task automatic step(input logic r, input logic fw, input logic fr, input logic [7:0] fd,
                        input logic lw, input logic lr, input logic [7:0] ld);
        reset = r; f_wr = fw; f_rd = fr; f_wdata = fd;
        l_wr = lw; l_rd = lr; l_wdata = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic lstep(input logic r, input logic w, input logic rd, input logic [7:0] d);
        step(r, 1'b0, 1'b0, 8'h00, w, rd, d);
    endtask

    function automatic vec_t v(input logic rst, input logic wr, input logic rd, input logic [7:0] d,
                               input logic rv, input logic [7:0] rdata, input int cnt,
                               input logic ov, input logic un);
        vec_t t;
        t.rst = rst; t.wr = wr; t.rd = rd; t.d = d;
        t.rv = rv; t.rdata = rdata; t.cnt = cnt; t.ov = ov; t.un = un;
        return t;
    endfunction

    // Reference models: plain queues following the buffer rules
    logic [7:0] qf[$];
    logic [7:0] ql[$];
    obs_t       ef, el;

    task automatic model_f(input logic r, input logic w, input logic rd, input logic [7:0] d);
        logic can_r, can_w;
        if (r) begin
            qf.delete();
            ef = mk(1'b0, 8'h00, 0, 1'b0, 1'b0);
        end else begin
            can_r = rd && (qf.size() > 0);
            can_w = w && ((qf.size() < 4) || rd);
            ef.rv = can_r;
            if (can_r) ef.rd = qf.pop_front();
            if (can_w) qf.push_back(d);
            ef = mk(ef.rv, ef.rd, qf.size(), ef.ov | (w & ~can_w), ef.un | (rd & ~can_r));
        end
    endtask

    task automatic model_l(input logic r, input logic w, input logic rd, input logic [7:0] d);
        logic ov, un;
        if (r) begin
            ql.delete();
            el = mk(1'b0, 8'h00, 0, 1'b0, 1'b0);
        end else begin
            ov = el.ov; un = el.un;
            el.rv = 1'b0;
            if (w && rd) begin
                el.rv = 1'b1;
                el.rd = d;
            end else if (rd) begin
                if (ql.size() > 0) begin
                    el.rv = 1'b1;
                    el.rd = ql.pop_back();
                end else un = 1'b1;
            end else if (w) begin
                if (ql.size() < 4) ql.push_back(d);
                else ov = 1'b1;
            end
            el = mk(el.rv, el.rd, ql.size(), ov, un);
        end
    endtask

    vec_t tv[$];

    initial begin
        reset = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_wdata = 8'h00;
        l_wr = 1'b0; l_rd = 1'b0; l_wdata = 8'h00;

        //               rst wr rd  d       rv rdata  cnt ov un
        tv.push_back(v(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h11, 0, 8'h00, 1, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h22, 0, 8'h00, 2, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h33, 0, 8'h00, 3, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h44, 0, 8'h00, 4, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h11, 3, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h22, 2, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h33, 1, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h44, 0, 0, 0));
        tv.push_back(v(0, 0, 0, 8'h00, 0, 8'h44, 0, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h11, 0, 8'h44, 1, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h22, 0, 8'h44, 2, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h33, 0, 8'h44, 3, 0, 0));
        tv.push_back(v(0, 1, 0, 8'h44, 0, 8'h44, 4, 0, 0));
        tv.push_back(v(0, 1, 1, 8'h55, 1, 8'h11, 4, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h22, 3, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h33, 2, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h44, 1, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h55, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 0, 8'h55, 0, 0, 1));
        tv.push_back(v(0, 1, 1, 8'h66, 0, 8'h55, 1, 0, 1));
        tv.push_back(v(0, 1, 0, 8'h77, 0, 8'h55, 2, 0, 1));
        tv.push_back(v(0, 1, 0, 8'h88, 0, 8'h55, 3, 0, 1));
        tv.push_back(v(0, 1, 0, 8'h99, 0, 8'h55, 4, 0, 1));
        tv.push_back(v(0, 1, 0, 8'hAA, 0, 8'h55, 4, 1, 1));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h66, 3, 1, 1));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h77, 2, 1, 1));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h88, 1, 1, 1));
        tv.push_back(v(0, 0, 1, 8'h00, 1, 8'h99, 0, 1, 1));
        tv.push_back(v(0, 0, 1, 8'h00, 0, 8'h99, 0, 1, 1));
        tv.push_back(v(0, 1, 0, 8'h01, 0, 8'h99, 1, 1, 1));
        tv.push_back(v(0, 1, 0, 8'h02, 0, 8'h99, 2, 1, 1));
        tv.push_back(v(0, 1, 0, 8'h03, 0, 8'h99, 3, 1, 1));
        tv.push_back(v(1, 1, 1, 8'h04, 0, 8'h00, 0, 0, 0));
        tv.push_back(v(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].wr, tv[i].rd, tv[i].d, 1'b0, 1'b0, 8'h00);
            chk_obs($sformatf("fifo_vec%0d", i), f_obs,
                    mk(tv[i].rv, tv[i].rdata, tv[i].cnt, tv[i].ov, tv[i].un));
        end

        // LIFO ordering, pass-through at empty/mid/full, overflow, reset, underflow
        lstep(1, 0, 0, 8'h00); chk_obs("lifo_rst",    l_obs, mk(0, 8'h00, 0, 0, 0));
        lstep(0, 1, 0, 8'hA1); chk_obs("lifo_push1",  l_obs, mk(0, 8'h00, 1, 0, 0));
        lstep(0, 1, 0, 8'hA2); chk_obs("lifo_push2",  l_obs, mk(0, 8'h00, 2, 0, 0));
        lstep(0, 1, 0, 8'hA3); chk_obs("lifo_push3",  l_obs, mk(0, 8'h00, 3, 0, 0));
        lstep(0, 0, 1, 8'h00); chk_obs("lifo_pop_a3", l_obs, mk(1, 8'hA3, 2, 0, 0));
        lstep(0, 0, 1, 8'h00); chk_obs("lifo_pop_a2", l_obs, mk(1, 8'hA2, 1, 0, 0));
        lstep(0, 1, 1, 8'hB0); chk_obs("lifo_pass",   l_obs, mk(1, 8'hB0, 1, 0, 0));
        lstep(0, 0, 1, 8'h00); chk_obs("lifo_pop_a1", l_obs, mk(1, 8'hA1, 0, 0, 0));
        lstep(0, 1, 1, 8'hB1); chk_obs("lifo_pass_e", l_obs, mk(1, 8'hB1, 0, 0, 0));
        lstep(0, 1, 0, 8'hC1); chk_obs("lifo_fill1",  l_obs, mk(0, 8'hB1, 1, 0, 0));
        lstep(0, 1, 0, 8'hC2); chk_obs("lifo_fill2",  l_obs, mk(0, 8'hB1, 2, 0, 0));
        lstep(0, 1, 0, 8'hC3); chk_obs("lifo_fill3",  l_obs, mk(0, 8'hB1, 3, 0, 0));
        lstep(0, 1, 0, 8'hC4); chk_obs("lifo_fill4",  l_obs, mk(0, 8'hB1, 4, 0, 0));
        lstep(0, 1, 1, 8'hD0); chk_obs("lifo_pass_f", l_obs, mk(1, 8'hD0, 4, 0, 0));
        lstep(0, 1, 0, 8'hE0); chk_obs("lifo_ovf",    l_obs, mk(0, 8'hD0, 4, 1, 0));
        lstep(0, 0, 1, 8'h00); chk_obs("lifo_pop_c4", l_obs, mk(1, 8'hC4, 3, 1, 0));
        lstep(1, 1, 1, 8'hF0); chk_obs("lifo_rst2",   l_obs, mk(0, 8'h00, 0, 0, 0));
        lstep(0, 0, 1, 8'h00); chk_obs("lifo_unf",    l_obs, mk(0, 8'h00, 0, 0, 1));

        // Randomized traffic on both buffers against the queue models
        model_f(1'b1, 1'b0, 1'b0, 8'h00);
        model_l(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk_obs("rand_fifo_rst", f_obs, ef);
        chk_obs("rand_lifo_rst", l_obs, el);
        for (int i = 0; i < 800; i++) begin
            logic r, fw, fr, lw, lr;
            logic [7:0] fd, ld;
            r  = ($urandom_range(0, 63) == 0);
            fw = 1'($urandom_range(0, 1));
            fr = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            lr = 1'($urandom_range(0, 1));
            fd = 8'($urandom);
            ld = 8'($urandom);
            model_f(r, fw, fr, fd);
            model_l(r, lw, lr, ld);
            step(r, fw, fr, fd, lw, lr, ld);
            chk_obs($sformatf("rand_fifo%0d", i), f_obs, ef);
            chk_obs($sformatf("rand_lifo%0d", i), l_obs, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
